// File: rtl/division_param.sv
// division_param: sequential restoring divider producing an unsigned
// fixed-point quotient (DIVIDEND_W integer bits, FRAC_W fractional bits),
// one bit per cycle MSB first, with remainder, divide-by-zero flag and
// early termination once every remaining quotient bit is provably zero.
module division_param #(
    parameter int DIVIDEND_W = 10,
    parameter int DIVISOR_W  = 3,
    parameter int FRAC_W     = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic [DIVIDEND_W-1:0]        in_data_1,
    input  logic [DIVISOR_W-1:0]         in_data_2,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [DIVIDEND_W+FRAC_W-1:0] out_data,
    output logic [DIVISOR_W-1:0]         out_rem,
    output logic                         out_div0
);

    localparam int QW = DIVIDEND_W + FRAC_W;
    localparam int IW = (QW > 1) ? $clog2(QW) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        FLUSH
    } state_t;

    state_t state;
    state_t state_next;

    logic [QW-1:0]        d;       // extended dividend {in_data_1, FRAC_W zeros}
    logic [DIVISOR_W-1:0] dv;      // captured divisor
    logic [DIVISOR_W-1:0] r;       // partial remainder, always < divisor
    logic [QW-1:0]        q;       // quotient bits produced so far
    logic [IW-1:0]        idx;     // bit currently being resolved

    logic [DIVISOR_W:0]   r_shift;
    logic [DIVISOR_W-1:0] r_next;
    logic                 q_bit;
    logic [QW-1:0]        q_step;
    logic                 low_zero;
    logic                 finish;

    // One restoring step for bit idx, plus the early-exit test: with a zero
    // remainder and no set dividend bits left below idx, all later quotient
    // bits are zero and the quotient register already holds the answer.
    always_comb begin
        r_shift = {r, d[idx]};
        q_bit   = (r_shift >= {1'b0, dv});
        r_next  = q_bit ? DIVISOR_W'(r_shift - {1'b0, dv}) : r_shift[DIVISOR_W-1:0];
        q_step  = q;
        q_step[idx] = q_bit;
        low_zero = 1'b1;
        for (int unsigned k = 0; k < QW; k++) begin
            if (k < 32'(idx) && d[k]) begin
                low_zero = 1'b0;
            end
        end
        finish = (idx == '0) || ((r_next == '0) && low_zero);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the ready indication.
    always_comb begin
        state_next = state;
        in_ready   = (state == IDLE);
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = (in_data_2 == '0) ? FLUSH : DIVIDE;
                end
            end
            DIVIDE: begin
                if (finish) begin
                    state_next = IDLE;
                end
            end
            FLUSH:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, iteration registers and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d         <= '0;
            dv        <= '0;
            r         <= '0;
            q         <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_rem   <= '0;
            out_div0  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        d   <= QW'(in_data_1) << FRAC_W;
                        dv  <= in_data_2;
                        r   <= '0;
                        q   <= '0;
                        idx <= IW'(QW - 1);
                    end
                end
                DIVIDE: begin
                    r <= r_next;
                    q <= q_step;
                    if (finish) begin
                        // Bits below idx were cleared at capture and never
                        // written, so q_step already has them forced to 0.
                        out_data  <= q_step;
                        out_rem   <= r_next;
                        out_div0  <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        idx <= idx - IW'(1);
                    end
                end
                FLUSH: begin
                    out_data  <= '1;
                    out_rem   <= '0;
                    out_div0  <= 1'b1;
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_division_param.sv
// tb_division_param: directed and randomized checks of division_param in its
// default build and in a 6/5/4 build, against an arithmetic reference model.
module tb_division_param;

    logic clk = 1'b0;
    logic rst_n;

    // Default build: 10/3/10, QW = 20
    logic        b_valid;
    logic [9:0]  b_a;
    logic [2:0]  b_b;
    logic        b_ready;
    logic        b_ov;
    logic [19:0] b_q;
    logic [2:0]  b_r;
    logic        b_z;

    // Small build: 6/5/4, QW = 10
    logic        s_valid;
    logic [5:0]  s_a;
    logic [4:0]  s_b;
    logic        s_ready;
    logic        s_ov;
    logic [9:0]  s_q;
    logic [4:0]  s_r;
    logic        s_z;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    division_param u_big (
        .clk(clk), .rst_n(rst_n), .in_valid(b_valid),
        .in_data_1(b_a), .in_data_2(b_b), .in_ready(b_ready),
        .out_valid(b_ov), .out_data(b_q), .out_rem(b_r), .out_div0(b_z)
    );

    division_param #(.DIVIDEND_W(6), .DIVISOR_W(5), .FRAC_W(4)) u_small (
        .clk(clk), .rst_n(rst_n), .in_valid(s_valid),
        .in_data_1(s_a), .in_data_2(s_b), .in_ready(s_ready),
        .out_valid(s_ov), .out_data(s_q), .out_rem(s_r), .out_div0(s_z)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain arithmetic. The step count is the first bit position i
    // (from the top) where the remainder of the prefix D>>i is zero and no
    // dividend bits remain below i; otherwise all QW bits are needed.
    function automatic void ref_div(input longint a, input longint b,
                                    input int dw, input int fw,
                                    output longint q, output longint r,
                                    output int k);
        int qw;
        longint dd;
        qw = dw + fw;
        if (b == 0) begin
            q = (longint'(1) << qw) - 1;
            r = 0;
            k = 1;
        end else begin
            dd = a << fw;
            q  = dd / b;
            r  = dd % b;
            k  = qw;
            for (int i = qw - 1; i >= 0; i--) begin
                if (((dd >> i) % b) == 0 && (dd & ((longint'(1) << i) - 1)) == 0) begin
                    k = qw - i;
                    break;
                end
            end
        end
    endfunction

    // One transaction on the chosen DUT (sel 0 = default, 1 = small),
    // entered and left #1 after a rising edge.
    task automatic run_op(input int sel, input longint a, input longint b, input string tag);
        longint eq, er;
        int     ek, cnt;
        bit     seen;
        ref_div(a, b, sel ? 6 : 10, sel ? 4 : 10, eq, er, ek);
        chk({tag, "_ready"}, sel ? s_ready : b_ready, 1);
        if (sel != 0) begin
            s_valid = 1'b1; s_a = a[5:0]; s_b = b[4:0];
        end else begin
            b_valid = 1'b1; b_a = a[9:0]; b_b = b[2:0];
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        b_valid = 1'b0;
        cnt  = 0;
        seen = 1'b0;
        while (!seen && cnt < 64) begin
            @(posedge clk); #1;
            cnt++;
            if (sel ? s_ov : b_ov) seen = 1'b1;
        end
        chk({tag, "_lat"}, cnt, ek);
        if (sel != 0) chk({tag, "_lat_le_qw"}, (cnt <= 10), 1);
        chk({tag, "_q"},    sel ? s_q : b_q, eq);
        chk({tag, "_rem"},  sel ? s_r : b_r, er);
        chk({tag, "_div0"}, sel ? s_z : b_z, (b == 0));
        chk({tag, "_rdy_at_ov"}, sel ? s_ready : b_ready, 1);
        @(posedge clk); #1;
        chk({tag, "_ov_pulse"}, sel ? s_ov : b_ov, 0);
    endtask

    initial begin
        longint eq, er;
        int     ek, pulses;
        bit     seen;

        b_valid = 1'b0; b_a = '0; b_b = '0;
        s_valid = 1'b0; s_a = '0; s_b = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #10;
        chk("rst_ready", b_ready, 1);
        chk("rst_ov",    b_ov, 0);
        chk("rst_q",     b_q, 0);
        chk("rst_rem",   b_r, 0);
        chk("rst_div0",  b_z, 0);
        chk("rst_s_ready", s_ready, 1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases on the default build
        run_op(0, 8,    2, "d8_2");
        run_op(0, 1023, 7, "d1023_7");
        run_op(0, 5,    0, "d5_0");
        run_op(0, 6,    3, "d6_3");
        chk("d6_3_const", b_q, 20'h00800);
        run_op(0, 0,    3, "d0_3");
        run_op(0, 1,    3, "d1_3");
        chk("d1_3_const", b_q, 20'h00155);
        run_op(0, 1023, 1, "d1023_1");
        run_op(0, 1023, 0, "d1023_0");
        chk("d1023_0_const", b_q, 20'hFFFFF);

        // Back-to-back: in_valid held high; only the first transfer and the
        // one in its out_valid cycle are accepted.
        b_a = 10'd1023; b_b = 3'd7; b_valid = 1'b1;
        @(posedge clk); #1;
        b_a = 10'd100; b_b = 3'd3;
        pulses = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 21) b_valid = 1'b0;
            if (b_ov) begin
                pulses++;
                if (pulses == 1) begin
                    ref_div(1023, 7, 10, 10, eq, er, ek);
                    chk("b2b_first_cyc", cyc, ek);
                end else begin
                    ref_div(100, 3, 10, 10, eq, er, ek);
                    chk("b2b_second_cyc", cyc, 21 + ek);
                end
                chk("b2b_q", b_q, eq);
                chk("b2b_rem", b_r, er);
            end
        end
        chk("b2b_pulses", pulses, 2);

        // Reset during DIVIDE aborts the operation.
        b_a = 10'd1023; b_b = 3'd7; b_valid = 1'b1;
        @(posedge clk); #1;
        b_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_ready", b_ready, 1);
        chk("midrst_ov",    b_ov, 0);
        chk("midrst_q",     b_q, 0);
        chk("midrst_rem",   b_r, 0);
        chk("midrst_div0",  b_z, 0);
        @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (b_ov) seen = 1'b1;
        end
        chk("midrst_no_ov", seen, 0);
        run_op(0, 8, 2, "post_rst_8_2");

        // Small build: boundaries, then random operands
        run_op(1, 63, 1,  "s63_1");
        run_op(1, 63, 31, "s63_31");
        run_op(1, 0,  0,  "s0_0");
        run_op(1, 32, 16, "s32_16");
        for (int n = 0; n < 300; n++) begin
            run_op(1, longint'($urandom_range(0, 63)), longint'($urandom_range(0, 31)), "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
